// File: rtl/id_pkg.sv
// Shared constants and state encoding for the ID digit sequencer.
package id_pkg;

  localparam int DEPTH  = 8;  // ROM entries scanned, power of two
  localparam int ADDR_W = 3;  // log2(DEPTH)
  localparam int DATA_W = 4;  // ROM digit width
  localparam int PASS_W = 4;  // completed-pass counter width

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [PASS_W-1:0] PASS_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Saturating increment for the pass counter.
  function automatic logic [PASS_W-1:0] pass_inc(input logic [PASS_W-1:0] cnt);
    return (cnt == PASS_MAX) ? cnt : cnt + PASS_W'(1);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider: raises tick for one cycle every TICK_DIV enabled
// cycles. Counting freezes while en is low; clr forces the count to zero.
module tick_prescaler #(
  parameter int TICK_DIV = 50000000,
  parameter int PRE_W    = 26
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam logic [PRE_W-1:0] CNT_LAST = PRE_W'(TICK_DIV - 1);

  logic [PRE_W-1:0] count;

  // tick is only meaningful while enabled, so a frozen count at the
  // terminal value never produces a spurious advance.
  assign tick = en && (count == CNT_LAST);

  // Count register: clear has priority, then wrap on tick, else increment.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for all clocked state so every register
    // samples the pre-edge values of the others, independent of block order.
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= tick ? '0 : count + PRE_W'(1);
    end
  end

endmodule

// File: rtl/id_seq_ctrl.sv
// ID digit ROM sequencer: scans the ROM at a prescaled rate with
// start/stop, pause with manual single-step, and single-pass or loop modes.
module id_seq_ctrl
  import id_pkg::*;
#(
  parameter int TICK_DIV = 50000000,
  parameter int PRE_W    = 26
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              step,
  input  logic              loop_en,
  input  logic [DATA_W-1:0] rom_data,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [DATA_W-1:0] digit,
  output logic              blank,
  output logic              busy,
  output logic              done,
  output logic [PASS_W-1:0] pass_cnt
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] digit_nxt;
  logic              blank_nxt;
  logic              done_nxt;
  logic [PASS_W-1:0] pass_nxt;
  logic              pre_en;
  logic              pre_clr;
  logic              tick;
  logic              advance;

  // Prescaler runs only in RUN and freezes as soon as pause is seen.
  tick_prescaler #(
    .TICK_DIV (TICK_DIV),
    .PRE_W    (PRE_W)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (pre_en),
    .clr  (pre_clr),
    .tick (tick)
  );

  assign busy = (state == RUN) || (state == PAUSE);

  // Next-state and datapath decode; priority stop > start > step > tick.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves
    // a variable unassigned, which would otherwise infer a latch.
    state_nxt = state;
    addr_nxt  = rom_addr;
    digit_nxt = digit;
    blank_nxt = blank;
    done_nxt  = 1'b0;
    pass_nxt  = pass_cnt;
    pre_en    = (state == RUN) && !pause;
    pre_clr   = 1'b0;
    advance   = 1'b0;

    // Display path follows the current state with one cycle of latency.
    unique case (state)
      RUN, PAUSE: begin
        digit_nxt = rom_data;
        blank_nxt = 1'b0;
      end
      DONE:    blank_nxt = 1'b0;
      default: blank_nxt = 1'b1;
    endcase

    if (stop) begin
      state_nxt = IDLE;
      addr_nxt  = '0;
      pre_clr   = 1'b1;
      blank_nxt = 1'b1;
      digit_nxt = digit;
    end else if (start) begin
      state_nxt = RUN;
      addr_nxt  = '0;
      pre_clr   = 1'b1;
      pass_nxt  = '0;
    end else begin
      advance = ((state == PAUSE) && step) || tick;

      if ((state == RUN) && pause)    state_nxt = PAUSE;
      if ((state == PAUSE) && !pause) state_nxt = RUN;

      if (advance) begin
        if (rom_addr != LAST_ADDR) begin
          addr_nxt = rom_addr + ADDR_W'(1);
        end else begin
          pass_nxt = pass_inc(pass_cnt);
          if (loop_en) begin
            addr_nxt = '0;
          end else begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
          end
        end
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rom_addr <= '0;
      digit    <= '0;
      blank    <= 1'b1;
      done     <= 1'b0;
      pass_cnt <= '0;
    end else begin
      state    <= state_nxt;
      rom_addr <= addr_nxt;
      digit    <= digit_nxt;
      blank    <= blank_nxt;
      done     <= done_nxt;
      pass_cnt <= pass_nxt;
    end
  end

endmodule

// File: tb/tb_id_seq_ctrl.sv
// Scoreboard bench for id_seq_ctrl with a 4-cycle step rate.
module tb_id_seq_ctrl;
  import id_pkg::*;

  localparam int TB_DIV = 4;

  // Field-select bits for an expectation entry.
  localparam logic [5:0] M_ADDR  = 6'b100000;
  localparam logic [5:0] M_DIGIT = 6'b010000;
  localparam logic [5:0] M_BLANK = 6'b001000;
  localparam logic [5:0] M_BUSY  = 6'b000100;
  localparam logic [5:0] M_DONE  = 6'b000010;
  localparam logic [5:0] M_PASS  = 6'b000001;
  localparam logic [5:0] M_ALL   = 6'b111111;

  typedef struct {
    string       tag;
    int          cyc;
    logic [5:0]  mask;
    logic [2:0]  addr;
    logic [3:0]  digit;
    logic        blank;
    logic        busy;
    logic        done;
    logic [3:0]  pass;
  } exp_t;

  logic clk = 1'b0;
  logic rst, start, stop, pause, step, loop_en;
  logic [DATA_W-1:0] rom_data;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] digit;
  logic blank, busy, done;
  logic [PASS_W-1:0] pass_cnt;

  logic [DATA_W-1:0] rom_mem [DEPTH];
  assign rom_data = rom_mem[rom_addr];

  int   cyc      = 0;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];
  int   done_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  id_seq_ctrl #(
    .TICK_DIV (TB_DIV),
    .PRE_W    (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .pause    (pause),
    .step     (step),
    .loop_en  (loop_en),
    .rom_data (rom_data),
    .rom_addr (rom_addr),
    .digit    (digit),
    .blank    (blank),
    .busy     (busy),
    .done     (done),
    .pass_cnt (pass_cnt)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Queue an expectation for the current cycle's negedge sample.
  task automatic expect_now(input string tag, input logic [5:0] mask,
                            input logic [2:0] a, input logic [3:0] d,
                            input logic bl, input logic bu, input logic dn,
                            input logic [3:0] p);
    exp_t e;
    e.tag = tag; e.cyc = cyc; e.mask = mask;
    e.addr = a; e.digit = d; e.blank = bl; e.busy = bu; e.done = dn; e.pass = p;
    exp_q.push_back(e);
  endtask

  task automatic cyc_step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: pops expectations due this cycle and compares masked fields.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      if (e.cyc < cyc) begin
        check({e.tag, ".stale"}, 16'(cyc), 16'(e.cyc));
      end else begin
        if (e.mask[5]) check({e.tag, ".addr"},  16'(rom_addr), 16'(e.addr));
        if (e.mask[4]) check({e.tag, ".digit"}, 16'(digit),    16'(e.digit));
        if (e.mask[3]) check({e.tag, ".blank"}, 16'(blank),    16'(e.blank));
        if (e.mask[2]) check({e.tag, ".busy"},  16'(busy),     16'(e.busy));
        if (e.mask[1]) check({e.tag, ".done"},  16'(done),     16'(e.done));
        if (e.mask[0]) check({e.tag, ".pass"},  16'(pass_cnt), 16'(e.pass));
      end
    end
  end

  // Done monitor: every done pulse must match a queued pass-count expectation.
  always @(negedge clk) begin
    if (!rst && done === 1'b1) begin
      if (done_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected none (cycle %0d)", cyc);
      end else begin
        check("done_pass", 16'(pass_cnt), 16'(done_q.pop_front()));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rom_mem = '{4'd1, 4'd9, 4'd0, 4'd0, 4'd1, 4'd6, 4'd2, 4'd1};
    rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; step = 1'b0; loop_en = 1'b0;

    // Reset state.
    cyc_step(2);
    rst = 1'b0;
    expect_now("reset", M_ALL, 3'd0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0);

    // Single pass: one advance every 4 cycles, digit lags address by one.
    start = 1'b1; cyc_step(1); start = 1'b0;
    expect_now("a_start", M_ALL, 3'd0, 4'd0, 1'b1, 1'b1, 1'b0, 4'd0);
    cyc_step(1);
    expect_now("a_d0", M_ALL, 3'd0, 4'd1, 1'b0, 1'b1, 1'b0, 4'd0);
    for (int k = 1; k < DEPTH; k++) begin
      cyc_step(3);
      expect_now($sformatf("a_adv%0d", k), M_ALL, 3'(k), rom_mem[k-1], 1'b0, 1'b1, 1'b0, 4'd0);
      cyc_step(1);
      expect_now($sformatf("a_dig%0d", k), M_ADDR | M_DIGIT, 3'(k), rom_mem[k], 1'b0, 1'b1, 1'b0, 4'd0);
    end
    done_q.push_back(1);
    cyc_step(3);
    expect_now("a_done", M_ALL, 3'd7, 4'd1, 1'b0, 1'b0, 1'b1, 4'd1);
    cyc_step(1);
    expect_now("a_hold1", M_ALL, 3'd7, 4'd1, 1'b0, 1'b0, 1'b0, 4'd1);
    cyc_step(4);
    expect_now("a_hold2", M_ALL, 3'd7, 4'd1, 1'b0, 1'b0, 1'b0, 4'd1);

    // Looping: 20 ticks, two wraps, busy throughout, no done.
    loop_en = 1'b1;
    start = 1'b1; cyc_step(1); start = 1'b0;
    expect_now("b_start", M_ALL, 3'd0, 4'd1, 1'b0, 1'b1, 1'b0, 4'd0);
    for (int i = 1; i <= 20 * TB_DIV; i++) begin
      cyc_step(1);
      if (i == 32 || i == 64)
        expect_now($sformatf("b_wrap%0d", i / 32), M_ALL, 3'd0, 4'd1, 1'b0, 1'b1, 1'b0, 4'(i / 32));
      else if (i == 80)
        expect_now("b_end", M_ALL, 3'd4, 4'd0, 1'b0, 1'b1, 1'b0, 4'd2);
      else
        expect_now("b_busy", M_BUSY | M_DONE, 3'd0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0);
    end

    // Stop coinciding with the tick at address 5: no advance, blanked.
    cyc_step(7);
    expect_now("d_pre", M_ALL, 3'd5, 4'd6, 1'b0, 1'b1, 1'b0, 4'd2);
    stop = 1'b1; cyc_step(1); stop = 1'b0;
    expect_now("d_stop", M_ALL, 3'd0, 4'd6, 1'b1, 1'b0, 1'b0, 4'd2);
    cyc_step(4);
    expect_now("d_idle", M_ALL, 3'd0, 4'd6, 1'b1, 1'b0, 1'b0, 4'd2);

    // Pause at prescaler 2 / address 3, single-step, then resume.
    loop_en = 1'b0;
    start = 1'b1; cyc_step(1); start = 1'b0;
    expect_now("c_start", M_ALL, 3'd0, 4'd6, 1'b1, 1'b1, 1'b0, 4'd0);
    cyc_step(14);
    expect_now("c_at3", M_ALL, 3'd3, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0);
    pause = 1'b1; cyc_step(1);
    expect_now("c_paused", M_ADDR | M_BUSY, 3'd3, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0);
    cyc_step(10);
    expect_now("c_frozen", M_ALL, 3'd3, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0);
    step = 1'b1; cyc_step(1); step = 1'b0;
    expect_now("c_step", M_ADDR | M_DIGIT, 3'd4, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0);
    cyc_step(1);
    expect_now("c_step_dig", M_ADDR | M_DIGIT, 3'd4, 4'd1, 1'b0, 1'b1, 1'b0, 4'd0);
    pause = 1'b0; cyc_step(1);
    expect_now("c_resume", M_ADDR | M_BUSY, 3'd4, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0);
    cyc_step(1);
    expect_now("c_res1", M_ADDR, 3'd4, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0);
    cyc_step(1);
    expect_now("c_res2", M_ADDR | M_DIGIT, 3'd5, 4'd1, 1'b0, 1'b1, 1'b0, 4'd0);

    // Restart mid-run at address 6 after three passes.
    loop_en = 1'b1;
    cyc_step(101);
    expect_now("e_pre", M_ALL, 3'd6, 4'd2, 1'b0, 1'b1, 1'b0, 4'd3);
    start = 1'b1; cyc_step(1); start = 1'b0;
    expect_now("e_restart", M_ALL, 3'd0, 4'd2, 1'b0, 1'b1, 1'b0, 4'd0);
    cyc_step(3);
    expect_now("e_wait", M_ADDR | M_DIGIT, 3'd0, 4'd1, 1'b0, 1'b1, 1'b0, 4'd0);
    cyc_step(1);
    expect_now("e_adv", M_ADDR | M_PASS, 3'd1, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0);

    // Reset while paused at address 2; a later step is ignored.
    cyc_step(4);
    expect_now("f_at2", M_ADDR | M_DIGIT, 3'd2, 4'd9, 1'b0, 1'b1, 1'b0, 4'd0);
    pause = 1'b1; cyc_step(1);
    expect_now("f_paused", M_ADDR | M_BUSY, 3'd2, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0);
    rst = 1'b1; cyc_step(1); rst = 1'b0;
    expect_now("f_reset", M_ALL, 3'd0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0);
    step = 1'b1; cyc_step(1); step = 1'b0;
    expect_now("f_step_ign", M_ALL, 3'd0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0);
    cyc_step(5);
    expect_now("f_idle", M_ALL, 3'd0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0);
    pause = 1'b0;

    // Drain: every queued expectation must have been consumed.
    cyc_step(2);
    @(negedge clk);
    #1;
    check("sb_drain", 16'(exp_q.size()), 16'd0);
    check("done_drain", 16'(done_q.size()), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/id_seq_ctrl.md
Name: id_seq_ctrl

Overview:
Sequencer for the 8-entry ID digit ROM. It drives the ROM address and registers the returned digit for the display mux. It replaces the free-running ID counter with a controlled scan: a prescaled step rate, start/stop, pause with manual single-step, and single-pass or looping modes. It sits between the front-panel controls and the ROM/display path.

Parameters:
DEPTH, 8, number of ROM entries scanned (power of two)
ADDR_W, 3, ROM address width, log2(DEPTH)
DATA_W, 4, ROM digit width
TICK_DIV, 50000000, clk cycles per automatic step (1 s at 50 MHz); must be >= 2
PRE_W, 26, prescaler width, ceil(log2(TICK_DIV))

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; begin scan at address 0
stop  in  1  one-cycle pulse; abort scan and blank the display
pause  in  1  level; freeze automatic stepping while high
step  in  1  one-cycle pulse; advance one address while paused
loop_en  in  1  1 = wrap to 0 after the last entry, 0 = single pass
rom_data  in  DATA_W  combinational digit from the ROM at rom_addr
rom_addr  out  ADDR_W  registered address to the ROM
digit  out  DATA_W  registered digit to the display mux
blank  out  1  1 = display off
busy  out  1  high in RUN or PAUSE
done  out  1  one-cycle pulse when a single pass completes
pass_cnt  out  4  completed passes since start, saturates at 15

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: state IDLE, rom_addr 0, prescaler 0, digit 0, blank 1, busy 0, done 0, pass_cnt 0.
- States: IDLE, RUN, PAUSE, DONE. busy = (RUN|PAUSE). done is high only on the cycle DONE is entered.
- Priority on any edge: rst > stop > start > step > tick.
- stop, from any state -> IDLE: rom_addr 0, prescaler 0, blank 1, digit holds its value. pass_cnt holds.
- start, from any state including RUN/PAUSE -> RUN: rom_addr 0, prescaler 0, pass_cnt 0.
- Digit path: in RUN and PAUSE, each cycle digit <= rom_data and blank <= 0, so digit = rom[rom_addr] with 1-cycle latency. In DONE, digit holds the last entry and blank stays 0. In IDLE, blank is 1.
- Prescaler counts only in RUN. tick = (prescaler == TICK_DIV-1); on tick the prescaler goes to 0. The first step occurs TICK_DIV cycles after start.
- Advance, on a RUN tick or on a PAUSE step:
  - If rom_addr < DEPTH-1: rom_addr + 1.
  - If rom_addr == DEPTH-1: pass_cnt + 1 (saturating).
    - loop_en=1: rom_addr -> 0, stay in the current state.
    - loop_en=0: -> DONE, rom_addr holds DEPTH-1, done pulses.
- RUN with pause=1 -> PAUSE on the next edge. The prescaler freezes at its value; a tick coinciding with pause=1 does not advance.
- PAUSE with pause=0 -> RUN; the prescaler resumes from its frozen value.
- step is ignored outside PAUSE. pause and step are ignored in IDLE/DONE.
- loop_en is sampled only at the last-address advance; changing it mid-pass is legal.

Decomposition:
- Package id_pkg: state enum (IDLE/RUN/PAUSE/DONE), DEPTH, ADDR_W, DATA_W constants.
- One sub-module: tick_prescaler (enable, clear, tick output, parameter TICK_DIV), reusable for display refresh.
- Everything else stays in id_seq_ctrl.

Test Plan:
- TICK_DIV=4, ROM = 1,9,0,0,1,6,2,1, loop_en=0, start -> rom_addr steps 0..7 every 4 cycles; digit sequence 1,9,0,0,1,6,2,1 (1-cycle lag); done pulses once at the 8th tick; DONE holds digit=1, blank=0, pass_cnt=1, busy=0.
- loop_en=1, start, run 20 ticks -> rom_addr wraps 7->0 twice, pass_cnt=2, done never asserted, busy=1 throughout.
- pause=1 at prescaler=2 with rom_addr=3, hold 10 cycles -> rom_addr stays 3; step pulse -> rom_addr=4, digit=1 next cycle; release pause -> next advance exactly 2 cycles later.
- stop asserted in the same cycle as a tick at rom_addr=5 -> IDLE, rom_addr=0, blank=1, busy=0, no advance.
- start mid-RUN at rom_addr=6 with pass_cnt=3 -> rom_addr=0, pass_cnt=0, prescaler=0, next advance 4 cycles later.
- rst asserted in PAUSE at rom_addr=2 -> all outputs return to reset values on the next edge; step afterwards is ignored.
